// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receive path.
// Entry word layout is {parity_err, stop_err, data}.
package uart_rx_fifo_pkg;

  localparam int MAX_UART_DATA_W = 8;
  localparam int FIFO_DEPTH      = 16;
  localparam int AFULL_THRESH    = 12;

  localparam int ENTRY_W  = MAX_UART_DATA_W + 2;
  localparam int PERR_BIT = MAX_UART_DATA_W + 1;
  localparam int SERR_BIT = MAX_UART_DATA_W;

endpackage

// File: rtl/uart_fifo_mem.sv
// Dual-port register array: synchronous write, asynchronous read.
// Shared by the UART receive and transmit FIFOs.
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer behind the UART controller.
// Pointers carry a wrap bit; status outputs are registered.
module uart_rx_fifo #(
  parameter int MAX_UART_DATA_W = uart_rx_fifo_pkg::MAX_UART_DATA_W,
  parameter int FIFO_DEPTH      = uart_rx_fifo_pkg::FIFO_DEPTH,
  parameter int ADDR_W          = $clog2(FIFO_DEPTH),
  parameter int AFULL_THRESH    = uart_rx_fifo_pkg::AFULL_THRESH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [MAX_UART_DATA_W-1:0] data_i,
  input  logic                       parity_err_i,
  input  logic                       stop_err_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic                       clr_flags_i,
  output logic [MAX_UART_DATA_W-1:0] rd_data_o,
  output logic                       rd_parity_err_o,
  output logic                       rd_stop_err_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       afull_o,
  output logic [ADDR_W:0]            level_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int EW = MAX_UART_DATA_W + 2;
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] AF  = (ADDR_W+1)'(AFULL_THRESH);

  logic [ADDR_W:0] wptr_q, rptr_q;
  logic [ADDR_W:0] wptr_d, rptr_d, lvl_d;
  logic            push_ok, pop_ok;
  logic            ovf_d, udf_d;
  logic [EW-1:0]   wdata, rdata;

  always_comb begin
    pop_ok  = pop_i && !empty_o;
    push_ok = push_i && (!full_o || pop_ok);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    ovf_d   = overflow_o && !clr_flags_i;
    udf_d   = underflow_o && !clr_flags_i;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + ONE;
      if (pop_ok)  rptr_d = rptr_q + ONE;
      // a new event beats a clear in the same cycle
      if (push_i && !push_ok) ovf_d = 1'b1;
      if (pop_i && !pop_ok)   udf_d = 1'b1;
    end
    lvl_d = wptr_d - rptr_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      empty_o     <= 1'b1;
      full_o      <= 1'b0;
      afull_o     <= 1'b0;
      level_o     <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      empty_o     <= (wptr_d == rptr_d);
      full_o      <= (wptr_d[ADDR_W] != rptr_d[ADDR_W]) &&
                     (wptr_d[ADDR_W-1:0] == rptr_d[ADDR_W-1:0]);
      afull_o     <= (lvl_d >= AF);
      level_o     <= lvl_d;
      overflow_o  <= ovf_d;
      underflow_o <= udf_d;
    end
  end

  assign wdata = {parity_err_i, stop_err_i, data_i};

  uart_fifo_mem #(
    .DEPTH (FIFO_DEPTH),
    .AW    (ADDR_W),
    .DW    (EW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (push_ok && !flush_i),
    .waddr_i (wptr_q[ADDR_W-1:0]),
    .wdata_i (wdata),
    .raddr_i (rptr_q[ADDR_W-1:0]),
    .rdata_o (rdata)
  );

  assign rd_data_o       = empty_o ? '0 : rdata[MAX_UART_DATA_W-1:0];
  assign rd_stop_err_o   = !empty_o && rdata[EW-2];
  assign rd_parity_err_o = !empty_o && rdata[EW-1];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected heads,
// a negedge monitor compares whenever an accepted pop is presented.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push_i = 1'b0;
  logic [7:0] data_i = '0;
  logic       parity_err_i = 1'b0;
  logic       stop_err_i = 1'b0;
  logic       pop_i = 1'b0;
  logic       flush_i = 1'b0;
  logic       clr_flags_i = 1'b0;
  logic [7:0] rd_data_o;
  logic       rd_parity_err_o;
  logic       rd_stop_err_o;
  logic       empty_o;
  logic       full_o;
  logic       afull_o;
  logic [4:0] level_o;
  logic       overflow_o;
  logic       underflow_o;

  int total  = 0;
  int passed = 0;
  logic [9:0] sbq [$];
  logic [9:0] mon_exp;

  uart_rx_fifo dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .push_i          (push_i),
    .data_i          (data_i),
    .parity_err_i    (parity_err_i),
    .stop_err_i      (stop_err_i),
    .pop_i           (pop_i),
    .flush_i         (flush_i),
    .clr_flags_i     (clr_flags_i),
    .rd_data_o       (rd_data_o),
    .rd_parity_err_o (rd_parity_err_o),
    .rd_stop_err_o   (rd_stop_err_o),
    .empty_o         (empty_o),
    .full_o          (full_o),
    .afull_o         (afull_o),
    .level_o         (level_o),
    .overflow_o      (overflow_o),
    .underflow_o     (underflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && pop_i && !empty_o) begin
      if (sbq.size() == 0) begin
        total++;
        $display("FAIL pop_unexpected: got %0h want none",
                 {rd_parity_err_o, rd_stop_err_o, rd_data_o});
      end else begin
        mon_exp = sbq.pop_front();
        chk("head", {rd_parity_err_o, rd_stop_err_o, rd_data_o}, mon_exp);
      end
    end
  end

  task automatic step(bit ps, logic [7:0] d, bit pe, bit se,
                      bit pp, bit fl, bit cl);
    push_i = ps; data_i = d; parity_err_i = pe; stop_err_i = se;
    pop_i = pp; flush_i = fl; clr_flags_i = cl;
    @(posedge clk); #1;
    push_i = 0; pop_i = 0; flush_i = 0; clr_flags_i = 0;
    parity_err_i = 0; stop_err_i = 0;
  endtask

  task automatic push_exp(logic [7:0] d, bit pe, bit se);
    sbq.push_back({pe, se, d});
    step(1, d, pe, se, 0, 0, 0);
  endtask

  task automatic pop1();
    step(0, 8'h00, 0, 0, 1, 0, 0);
  endtask

  task automatic chk_idle(string tag);
    chk({tag, "_empty"}, empty_o, 1);
    chk({tag, "_level"}, level_o, 0);
    chk({tag, "_data"}, {rd_parity_err_o, rd_stop_err_o, rd_data_o}, 0);
    chk({tag, "_full"}, full_o, 0);
    chk({tag, "_afull"}, afull_o, 0);
    chk({tag, "_ovf"}, overflow_o, 0);
    chk({tag, "_udf"}, underflow_o, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_idle("reset");
    step(0, 8'h00, 0, 0, 0, 0, 0);
    chk_idle("idle");

    // single character with parity error
    push_exp(8'hA5, 1, 0);
    chk("a5_data", rd_data_o, 8'hA5);
    chk("a5_perr", rd_parity_err_o, 1);
    chk("a5_empty", empty_o, 0);
    chk("a5_level", level_o, 1);
    pop1();
    chk("a5_popped_empty", empty_o, 1);

    // fill, overflow, drain
    for (int i = 0; i < 16; i++) begin
      push_exp(8'(i), 0, 0);
      chk("fill_level", level_o, i + 1);
      chk("fill_afull", afull_o, (i + 1 >= 12) ? 1 : 0);
      chk("fill_full", full_o, (i == 15) ? 1 : 0);
    end
    step(1, 8'hFF, 0, 0, 0, 0, 0);
    chk("ovf_set", overflow_o, 1);
    chk("ovf_level", level_o, 16);
    chk("ovf_head", rd_data_o, 8'h00);
    for (int i = 0; i < 16; i++) pop1();
    chk("drain_empty", empty_o, 1);
    chk("ovf_sticky", overflow_o, 1);
    step(0, 8'h00, 0, 0, 0, 0, 1);
    chk("ovf_clr", overflow_o, 0);
    chk("drain_sb", sbq.size(), 0);

    // push and pop together while full
    for (int i = 0; i < 16; i++) push_exp(8'(i), 0, i[0]);
    chk("full2", full_o, 1);
    sbq.push_back({2'b00, 8'h55});
    step(1, 8'h55, 0, 0, 1, 0, 0);
    chk("pp_level", level_o, 16);
    chk("pp_full", full_o, 1);
    chk("pp_head", {rd_stop_err_o, rd_data_o}, {1'b1, 8'h01});
    chk("pp_ovf", overflow_o, 0);
    for (int i = 0; i < 16; i++) pop1();
    chk("pp_drain_sb", sbq.size(), 0);
    chk("pp_drain_empty", empty_o, 1);

    // pop on empty with a simultaneous push
    sbq.push_back({2'b00, 8'h3C});
    step(1, 8'h3C, 0, 0, 1, 0, 0);
    chk("udf_set", underflow_o, 1);
    chk("udf_level", level_o, 1);
    chk("udf_head", rd_data_o, 8'h3C);
    step(0, 8'h00, 0, 0, 0, 0, 1);
    chk("udf_clr", underflow_o, 0);
    pop1();
    chk("udf_empty", empty_o, 1);

    // clear and new event in the same cycle: set wins
    step(0, 8'h00, 0, 0, 1, 0, 0);
    step(0, 8'h00, 0, 0, 1, 0, 1);
    chk("udf_setwins", underflow_o, 1);

    // wrap pointers at level 5, then flush
    for (int i = 0; i < 5; i++) push_exp(8'h40 + 8'(i), 0, 1);
    for (int i = 0; i < 40; i++) begin
      sbq.push_back({2'b10, 8'h80 + 8'(i)});
      step(1, 8'h80 + 8'(i), 1, 0, 1, 0, 0);
    end
    chk("wrap_level", level_o, 5);
    chk("wrap_head", {rd_parity_err_o, rd_data_o}, {1'b1, 8'hA3});
    step(1, 8'hEE, 0, 0, 0, 1, 0);
    sbq.delete();
    chk("flush_level", level_o, 0);
    chk("flush_empty", empty_o, 1);
    chk("flush_udf", underflow_o, 1);
    chk("flush_ovf", overflow_o, 0);
    chk("flush_data", rd_data_o, 0);

    // reset in the middle of traffic, no clock edge needed
    push_exp(8'h21, 0, 0);
    push_exp(8'h22, 1, 1);
    #2 rst = 1'b1;
    #1;
    sbq.delete();
    chk_idle("midrst");
    @(posedge clk); #1 rst = 1'b0;
    chk_idle("postrst");
    push_exp(8'h11, 0, 1);
    chk("postrst_level", level_o, 1);
    chk("postrst_head", {rd_stop_err_o, rd_data_o}, {1'b1, 8'h11});
    pop1();
    chk("end_empty", empty_o, 1);
    chk("end_sb", sbq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
